ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Execute-stage iterative multiply/divide unit that owns the HI/LO registers.
//  It sits directly downstream of the ID/EX pipeline register and consumes its RdDataA/RdDataB and funct outputs.
//  It executes MULT/MULTU/DIV/DIVU over multiple cycles, services MTHI/MTLO/MFHI/MFLO,
//  and raises a stall that freezes the front end while an issued op must wait.
// PARAMETERS
//  DATA_WIDTH  32  operand and HI/LO width; iteration count = DATA_WIDTH
//  CNT_WIDTH   6   iteration counter width; must hold DATA_WIDTH
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  Flush       in   1   ID/EX flush (cHazard); blocks acceptance of this cycle's op
//  OpValid     in   1   ID/EX holds a HI/LO-class instruction
//  FunctIn     in   6   funct field from ID/EX
//  RdDataAIn   in   32  rs operand (dividend / multiplicand / MT source)
//  RdDataBIn   in   32  rt operand (divisor / multiplier)
//  StallOut    out  1   combinational; freeze PC, IF/ID and ID/EX this cycle
//  MfDataOut   out  32  combinational; HI for MFHI, LO for MFLO, else 0
//  HiOut       out  32  HI register
//  LoOut       out  32  LO register
//  BusyOut     out  1   state != IDLE
// BEHAVIOUR
//  Funct codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
//   Any other funct with OpValid=1 is ignored.
//  Reset (rst=0, any time, including mid-op):
//   state=IDLE, HI=LO=0, counter=0, internal regs=0, BusyOut=0.
//   StallOut=0, MfDataOut=0 while in reset.
//  Accept: op is accepted when OpValid=1, Flush=0, funct is valid, and state=IDLE.
//  StallOut = OpValid & ~Flush & valid funct & (state!=IDLE).
//   The stalled op is held in ID/EX by the stall and is re-presented every cycle.
//  States: IDLE, MUL, DIV, FIXUP.
//  IDLE:
//   - MTHI/MTLO: HI (resp. LO) <= rs at the next edge; stays in IDLE.
//   - MFHI/MFLO: MfDataOut = current HI/LO in the same cycle, no latency.
//   - MULT*: latch |rs|,|rt| for signed ops (raw values for unsigned), record result sign; counter=32; go to MUL.
//   - DIV*: same operand latching; go to DIV.
//   - DIV*/DIVU with rt=0: skip iteration; HI<=rs, LO<=32'hFFFFFFFF at the next edge; stay in IDLE (1-cycle op).
//  MUL: radix-2 shift-add, one bit per cycle, 64-bit accumulator; counter-- each cycle; counter==1 -> FIXUP.
//  DIV: restoring, one quotient bit per cycle, 33-bit partial-remainder subtract; counter==1 -> FIXUP.
//  FIXUP:
//   - MULT: negate the 64-bit product if signs differed.
//   - DIV: negate the quotient if signs differed; remainder takes the dividend's sign.
//   - Write {HI,LO}: product split HI=upper, LO=lower; division LO=quotient, HI=remainder.
//   - Go to IDLE.
//  Latency: an accepted MUL/DIV updates HI/LO at edge 33 after acceptance (32 iterations + FIXUP).
//   A dependent op presented from cycle 1 stalls for exactly 33 cycles.
//  Arithmetic is modulo 2^32 per half.
//   Signed 0x80000000 / -1 gives LO=0x80000000, HI=0 with no trap.
//   Signed |0x80000000| is handled as the unsigned value 0x80000000.
//  Flush while busy does not abort an in-flight op; Flush only blocks new acceptance.
//  Simultaneous FIXUP and new-op presentation: the op stalls that cycle and is accepted the next cycle (state=IDLE).
// STRUCTURE
//  Shared header (Types.v):
//   - MD_FUNCT_* constants, MD_STATE_* encodings (2-bit), `MdStatePath.
//   - Reuse `DataPath / `FunctPath.
//  Sub-module muldiv_iter_core: accumulator/remainder registers plus one-step add/subtract datapath.
//   The FSM, counter, sign handling and HI/LO registers stay in ex_muldiv_unit.
// TESTING
//  1. MTHI rs=0x12345678, then MFHI next cycle -> MfDataOut=0x12345678, StallOut=0.
//  2. MULTU 0xFFFFFFFF*0xFFFFFFFF, then MFLO held -> StallOut=1 for 33 cycles;
//     then HI=0xFFFFFFFE, LO=0x00000001.
//  3. MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  4. DIVU 100/0 -> HI=100, LO=0xFFFFFFFF one edge later, BusyOut never 1;
//     DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5. MULT accepted, Flush pulses at cycle 5 -> result still written at edge 33;
//     OpValid+Flush in IDLE -> no state change.
//  6. rst=0 at cycle 10 of a DIV -> immediately state=IDLE, HI=LO=0, StallOut=0;
//     after release, a new MULT is accepted normally.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: funct codes,
// FSM state type and funct decode helpers.
package ex_muldiv_unit_pkg;

    localparam logic [5:0] FunctMfhi  = 6'h10;
    localparam logic [5:0] FunctMthi  = 6'h11;
    localparam logic [5:0] FunctMflo  = 6'h12;
    localparam logic [5:0] FunctMtlo  = 6'h13;
    localparam logic [5:0] FunctMult  = 6'h18;
    localparam logic [5:0] FunctMultu = 6'h19;
    localparam logic [5:0] FunctDiv   = 6'h1A;
    localparam logic [5:0] FunctDivu  = 6'h1B;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMul   = 2'd1,
        StDiv   = 2'd2,
        StFixup = 2'd3
    } md_state_e;

    // True for any funct this unit services.
    function automatic logic is_md_funct(input logic [5:0] funct);
        logic hit;
        case (funct)
            FunctMfhi, FunctMthi, FunctMflo, FunctMtlo,
            FunctMult, FunctMultu, FunctDiv, FunctDivu: hit = 1'b1;
            default:                                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_mul_funct(input logic [5:0] funct);
        return (funct == FunctMult) || (funct == FunctMultu);
    endfunction

    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FunctDiv) || (funct == FunctDivu);
    endfunction

    // MULT and DIV treat operands as two's complement; the U variants do not.
    function automatic logic is_signed_funct(input logic [5:0] funct);
        return (funct == FunctMult) || (funct == FunctDiv);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Iteration datapath: a 2W-bit accumulator plus the latched second operand.
// Multiply: acc = {partial product, remaining multiplier bits}, shift-add per step.
// Divide:   acc = {partial remainder, dividend/quotient bits}, restoring step.
module ex_muldiv_unit_iter_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic                      div_mode,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic [2*DATA_WIDTH-1:0]   acc
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0]   opnd_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_next;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;

    // One shift-add or one restoring-subtract step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_next  = {mul_sum, acc_q[W-1:1]};
        if (div_mode) begin
            if (!div_diff[W]) begin
                acc_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end
    end

    // Operand load on acceptance, otherwise advance one step while iterating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= {{W{1'b0}}, op_a};
            opnd_q <= op_b;
        end else if (step) begin
            acc_q  <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit owning HI/LO. Runs MULT/MULTU/DIV/DIVU
// over DATA_WIDTH iterations plus a sign fixup cycle and stalls dependent HI/LO ops.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Flush,
    input  logic                  OpValid,
    input  logic [5:0]            FunctIn,
    input  logic [DATA_WIDTH-1:0] RdDataAIn,
    input  logic [DATA_WIDTH-1:0] RdDataBIn,
    output logic                  StallOut,
    output logic [DATA_WIDTH-1:0] MfDataOut,
    output logic [DATA_WIDTH-1:0] HiOut,
    output logic [DATA_WIDTH-1:0] LoOut,
    output logic                  BusyOut
);

    localparam int unsigned W = DATA_WIDTH;

    md_state_e          state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;

    logic               valid_funct;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;
    logic               div_zero;
    logic               core_load;
    logic               core_step;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quot_fix;
    logic [W-1:0]       rem_fix;

    assign valid_funct = is_md_funct(FunctIn);
    assign accept      = OpValid & ~Flush & valid_funct & (state == StIdle);
    assign StallOut    = rst & OpValid & ~Flush & valid_funct & (state != StIdle);
    assign BusyOut     = (state != StIdle);
    assign HiOut       = hi;
    assign LoOut       = lo;

    // Operand magnitudes; signed 0x80000000 negates to itself, which is the right magnitude.
    assign a_neg     = is_signed_funct(FunctIn) & RdDataAIn[W-1];
    assign b_neg     = is_signed_funct(FunctIn) & RdDataBIn[W-1];
    assign a_mag     = a_neg ? (~RdDataAIn + 1'b1) : RdDataAIn;
    assign b_mag     = b_neg ? (~RdDataBIn + 1'b1) : RdDataBIn;
    assign div_zero  = (RdDataBIn == '0);
    assign core_load = accept & (is_mul_funct(FunctIn) | (is_div_funct(FunctIn) & ~div_zero));
    assign core_step = (state == StMul) || (state == StDiv);

    // Same-cycle HI/LO read for MFHI/MFLO.
    always_comb begin
        MfDataOut = '0;
        if (rst && OpValid) begin
            case (FunctIn)
                FunctMfhi: MfDataOut = hi;
                FunctMflo: MfDataOut = lo;
                default:   MfDataOut = '0;
            endcase
        end
    end

    // Sign restoration applied in FIXUP.
    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quot_fix = neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rem_fix  = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
    end

    ex_muldiv_unit_iter_core #(
        .DATA_WIDTH (W)
    ) u_iter_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .div_mode (state == StDiv),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .acc      (acc)
    );

    // Control FSM, iteration counter, sign flags and HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        case (FunctIn)
                            FunctMthi: hi <= RdDataAIn;
                            FunctMtlo: lo <= RdDataAIn;
                            FunctMult, FunctMultu: begin
                                state   <= StMul;
                                cnt     <= CNT_WIDTH'(W);
                                is_div  <= 1'b0;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= 1'b0;
                            end
                            FunctDiv, FunctDivu: begin
                                if (div_zero) begin
                                    // Divide by zero completes immediately without iterating.
                                    hi <= RdDataAIn;
                                    lo <= '1;
                                end else begin
                                    state   <= StDiv;
                                    cnt     <= CNT_WIDTH'(W);
                                    is_div  <= 1'b1;
                                    neg_res <= a_neg ^ b_neg;
                                    neg_rem <= a_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StMul, StDiv: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= StFixup;
                    end
                end
                StFixup: begin
                    if (is_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed scenarios plus randomized mul/div checked
// against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Flush = 1'b0;
    logic        OpValid = 1'b0;
    logic [5:0]  FunctIn = 6'h0;
    logic [31:0] RdDataAIn = '0;
    logic [31:0] RdDataBIn = '0;
    logic        StallOut;
    logic [31:0] MfDataOut;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        BusyOut;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Flush     (Flush),
        .OpValid   (OpValid),
        .FunctIn   (FunctIn),
        .RdDataAIn (RdDataAIn),
        .RdDataBIn (RdDataBIn),
        .StallOut  (StallOut),
        .MfDataOut (MfDataOut),
        .HiOut     (HiOut),
        .LoOut     (LoOut),
        .BusyOut   (BusyOut)
    );

    // Reference: HI/LO results from plain integer arithmetic.
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        if (f == MULTU) begin
            up = {32'h0, a} * {32'h0, b};
            hi = up[63:32]; lo = up[31:0];
        end else if (f == MULT) begin
            sp = sa * sb;
            up = sp;
            hi = up[63:32]; lo = up[31:0];
        end else if (b == 32'h0) begin
            hi = a; lo = 32'hFFFF_FFFF;
        end else if (f == DIVU) begin
            lo = a / b; hi = a % b;
        end else begin
            sq = sa / sb; sr = sa % sb;
            lo = sq[31:0]; hi = sr[31:0];
        end
    endfunction

    // Issue op, then hold MFLO and count stall cycles until LO is readable.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_stalls, input string name);
        int stalls;
        @(negedge clk);
        OpValid = 1'b1; FunctIn = f; RdDataAIn = a; RdDataBIn = b;
        @(negedge clk);
        FunctIn = MFLO;
        #1;
        stalls = 0;
        while (StallOut === 1'b1 && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        total_cnt++;
        if (stalls !== exp_stalls)
            $display("FAIL %s stalls: got %0d expected %0d", name, stalls, exp_stalls);
        else pass_cnt++;
        total_cnt++;
        if (MfDataOut !== exp_lo)
            $display("FAIL %s mflo: got %h expected %h", name, MfDataOut, exp_lo);
        else pass_cnt++;
        total_cnt++;
        if (HiOut !== exp_hi || LoOut !== exp_lo)
            $display("FAIL %s hi/lo: got %h/%h expected %h/%h", name, HiOut, LoOut,
                     exp_hi, exp_lo);
        else pass_cnt++;
        OpValid = 1'b0;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        OpValid = 1'b1; FunctIn = f; RdDataAIn = v;
        @(negedge clk);
        OpValid = 1'b0;
    endtask

    task automatic test_reset();
        OpValid = 1'b1; FunctIn = MFHI;
        #12;
        total_cnt++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0 || BusyOut !== 1'b0 || StallOut !== 1'b0 ||
            MfDataOut !== 32'h0)
            $display("FAIL reset: got hi=%h lo=%h busy=%b stall=%b mf=%h expected zeros",
                     HiOut, LoOut, BusyOut, StallOut, MfDataOut);
        else pass_cnt++;
        OpValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mthi_mfhi();
        mt(MTHI, 32'h1234_5678);
        OpValid = 1'b1; FunctIn = MFHI;
        #1;
        total_cnt++;
        if (MfDataOut !== 32'h1234_5678 || StallOut !== 1'b0)
            $display("FAIL mfhi: got %h stall=%b expected 12345678 stall=0", MfDataOut, StallOut);
        else pass_cnt++;
        OpValid = 1'b0;
        mt(MTLO, 32'hCAFE_0001);
        OpValid = 1'b1; FunctIn = MFLO;
        #1;
        total_cnt++;
        if (MfDataOut !== 32'hCAFE_0001 || HiOut !== 32'h1234_5678)
            $display("FAIL mflo: got mf=%h hi=%h expected cafe0001/12345678", MfDataOut, HiOut);
        else pass_cnt++;
        OpValid = 1'b0;
    endtask

    task automatic test_multu_stall();
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu");
    endtask

    task automatic test_signed();
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult_neg");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg");
    endtask

    task automatic test_div_edges();
        @(negedge clk);
        OpValid = 1'b1; FunctIn = DIVU; RdDataAIn = 32'd100; RdDataBIn = 32'd0;
        @(negedge clk);
        OpValid = 1'b0;
        total_cnt++;
        if (BusyOut !== 1'b0 || HiOut !== 32'd100 || LoOut !== 32'hFFFF_FFFF)
            $display("FAIL divu_zero: got busy=%b hi=%h lo=%h expected 0/00000064/ffffffff",
                     BusyOut, HiOut, LoOut);
        else pass_cnt++;
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, "div_ovf");
    endtask

    task automatic test_flush();
        mt(MTHI, 32'h5555_5555);
        mt(MTLO, 32'h5555_5555);
        @(negedge clk);
        OpValid = 1'b1; FunctIn = MULT; RdDataAIn = 32'hFFFF_FFFD; RdDataBIn = 32'd7;
        @(negedge clk);
        OpValid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            Flush = (k == 5);
        end
        Flush = 1'b0;
        total_cnt++;
        if (BusyOut !== 1'b1 || HiOut !== 32'h5555_5555)
            $display("FAIL flush_edge32: got busy=%b hi=%h expected 1/55555555", BusyOut, HiOut);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (BusyOut !== 1'b0 || HiOut !== 32'hFFFF_FFFF || LoOut !== 32'hFFFF_FFEB)
            $display("FAIL flush_edge33: got busy=%b hi=%h lo=%h expected 0/ffffffff/ffffffeb",
                     BusyOut, HiOut, LoOut);
        else pass_cnt++;
        // Flushed ops in IDLE must not be accepted.
        OpValid = 1'b1; Flush = 1'b1; FunctIn = MTHI; RdDataAIn = 32'h0BAD_0BAD;
        @(negedge clk);
        FunctIn = MULT;
        @(negedge clk);
        total_cnt++;
        if (HiOut !== 32'hFFFF_FFFF || BusyOut !== 1'b0 || StallOut !== 1'b0)
            $display("FAIL flush_idle: got hi=%h busy=%b stall=%b expected ffffffff/0/0",
                     HiOut, BusyOut, StallOut);
        else pass_cnt++;
        OpValid = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        mt(MTHI, 32'hA5A5_A5A5);
        @(negedge clk);
        OpValid = 1'b1; FunctIn = DIV; RdDataAIn = 32'd1000; RdDataBIn = 32'd7;
        @(negedge clk);
        FunctIn = MFLO;
        repeat (9) @(negedge clk);
        total_cnt++;
        if (StallOut !== 1'b1 || BusyOut !== 1'b1)
            $display("FAIL pre_reset: got stall=%b busy=%b expected 1/1", StallOut, BusyOut);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (BusyOut !== 1'b0 || HiOut !== 32'h0 || LoOut !== 32'h0 || StallOut !== 1'b0 ||
            MfDataOut !== 32'h0)
            $display("FAIL mid_reset: got busy=%b hi=%h lo=%h stall=%b mf=%h expected zeros",
                     BusyOut, HiOut, LoOut, StallOut, MfDataOut);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1; OpValid = 1'b0;
        run_op(MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33, "post_reset");
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = a & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if ((f == DIV || f == DIVU) && $urandom_range(0, 5) == 0) b = 32'h0;
            model(f, a, b, eh, el);
            run_op(f, a, b, eh, el, ((f == DIV || f == DIVU) && b == 32'h0) ? 0 : 33,
                   $sformatf("rand%0d_f%h", i, f));
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mfhi();
        test_multu_stall();
        test_signed();
        test_div_edges();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
